sd_sector_arbiter: RTL and testbench
====================================

// Module: sd_sector_arbiter
// PURPOSE
//  Shares the single hps_io sector channel (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) among NREQ
//  virtual-drive requesters (FDD0, FDD1, HDD, spare). Grants one requester at a time, round-robin.
//  Holds the grant for one full sector transfer and steers sd_buff_din from the owner.
//  Reports completion or timeout per requester. Sits between the PC88 disk controllers and hps_io.
// PARAMETERS
//  NREQ     4         number of requesters (2..8)
//  LBA_W    32        sector address width
//  TIMEOUT  24'd8000000  clk_sys cycles allowed from issue to sd_ack rise before abort
// PORTS
//  clk_sys       in   1            system clock, all logic on rising edge
//  reset         in   1            asynchronous, active-high; clears all state
//  req_rd        in   NREQ         per-requester read request, level, held until done/err
//  req_wr        in   NREQ         per-requester write request, level, held until done/err
//  req_lba       in   NREQ*LBA_W   per-requester LBA; slice i = [i*LBA_W +: LBA_W]
//  req_buff_din  in   NREQ*8       per-requester write data for current sd_buff_addr
//  req_done      out  NREQ         1-cycle pulse to owner on successful transfer end
//  req_err       out  NREQ         1-cycle pulse to owner on timeout abort
//  sd_lba        out  LBA_W        LBA latched at grant
//  sd_rd         out  NREQ         one-hot read strobe to hps_io
//  sd_wr         out  NREQ         one-hot write strobe to hps_io
//  sd_ack        in   NREQ         per-drive ack from hps_io
//  sd_buff_din   out  8            mux of req_buff_din by owner (combinational)
//  busy          out  1            high from grant until return to IDLE
//  owner         out  $clog2(NREQ) index of current/last granted requester
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0.
//  States: IDLE -> ISSUE -> WAIT_ACK -> XFER -> DONE -> IDLE; WAIT_ACK -> ABORT -> IDLE.
//  IDLE: pending[i] = req_rd[i]|req_wr[i]. Pick first pending at or after rr pointer (wrapping).
//   Same cycle: latch owner, sd_lba <= req_lba[owner], op <= write if req_wr else read
//   (rd and wr together: write wins); next ISSUE. No pending: stay, busy=0.
//  ISSUE: assert sd_rd[owner] or sd_wr[owner] (registered, one-hot, other bits 0); clear counter;
//   busy=1; next WAIT_ACK. Grant latency: request seen in IDLE -> strobe high 2 cycles later.
//  WAIT_ACK: strobe held. On sd_ack[owner] rising (registered edge detect): drop strobe same
//   clock, go XFER. Counter increments each cycle; at TIMEOUT-1 without ack: drop strobe, ABORT.
//  XFER: wait sd_ack[owner] low; then DONE. sd_buff_din always = req_buff_din[owner].
//  DONE: req_done[owner]=1 one cycle; rr pointer <= owner+1 (mod NREQ); next IDLE.
//  ABORT: req_err[owner]=1 one cycle; rr pointer <= owner+1; next IDLE.
//  Requester drops request after ISSUE: transfer still completes; done pulse still issued.
//  Ack on non-owner bits ignored. Ack already high in ISSUE (stale): not an edge; wait for fall+rise.
//  A requester may re-request the cycle after done; it is served only after others pending (rr).
//  Reset mid-transfer: strobes drop immediately (async), no done/err pulse.
// STRUCTURE
//  Package sd_arb_pkg: state enum (IDLE,ISSUE,WAIT_ACK,XFER,DONE,ABORT), op enum (OP_RD,OP_WR).
//  Sub-module rr_pick: combinational round-robin first-set finder (pending, ptr -> idx, valid).
//  Timeout counter: 24 bits, saturating, active only in WAIT_ACK.
// TESTING
//  1 NREQ=4: req_rd[0]=1 lba=0x10; ack[0] rises 5 cycles after sd_rd[0] -> sd_lba=0x10, sd_rd=4'b0001
//    for exactly 5 cycles, req_done[0] one pulse after ack falls, busy low next cycle.
//  2 req_wr[1] and req_rd[3] same cycle, rr=0 -> owner 1 served (sd_wr=4'b0010), then owner 3
//    (sd_rd=4'b1000); rr pointer then 0.
//  3 req_rd[2]&req_wr[2] together -> sd_wr[2] asserted, sd_rd stays 0.
//  4 TIMEOUT=16, no ack -> strobe drops after 16 cycles in WAIT_ACK, req_err[owner] pulse, no done.
//  5 reset asserted during XFER -> sd_rd/sd_wr/busy 0 asynchronously; after release owner 0 re-served.
//  6 ack[2] toggled while owner=0 -> ignored; sd_buff_din tracks req_buff_din[0] throughout.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types for the SD sector arbiter: controller states and the
// direction of the sector transfer latched at grant time.
package sd_arb_pkg;

    // Width of the issue-to-ack timeout counter.
    localparam int TMO_W = 24;

    // Arbiter controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        XFER     = 3'd3,
        DONE     = 3'd4,
        ABORT    = 3'd5
    } arb_state_e;

    // Direction of the granted sector transfer.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_e;

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Round-robin first-set finder: returns the first pending requester at or
// after the pointer, wrapping around the end of the vector.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    // Scan from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        int j;
        j       = 0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (pending_i[j]) begin
                idx_o   = IW'(j);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares the single hps_io sector channel among NREQ virtual drives.
// One requester is granted at a time in round-robin order and keeps the
// grant for a whole sector transfer; completion or timeout is pulsed back.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               LBA_W   = 32,
    parameter logic [TMO_W-1:0] TIMEOUT = 24'd8000000
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_rd,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*LBA_W-1:0]    req_lba,
    input  logic [NREQ*8-1:0]        req_buff_din,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err,
    output logic [LBA_W-1:0]         sd_lba,
    output logic [NREQ-1:0]          sd_rd,
    output logic [NREQ-1:0]          sd_wr,
    input  logic [NREQ-1:0]          sd_ack,
    output logic [7:0]               sd_buff_din,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int IW = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    arb_op_e           op_q, op_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic [NREQ-1:0]   rd_q, rd_d;
    logic [NREQ-1:0]   wr_q, wr_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [NREQ-1:0]   ackPrev_q;
    logic              busy_q, busy_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   pending;
    logic [IW-1:0]     pickIdx;
    logic              pickValid;
    logic              ackRise;
    logic [NREQ-1:0]   ownerOneHot;
    logic [IW-1:0]     ownerNext;

    assign pending     = req_rd | req_wr;
    assign ackRise     = sd_ack[owner_q] & ~ackPrev_q[owner_q];
    assign ownerOneHot = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    assign ownerNext   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .pending_i (pending),
        .ptr_i     (ptr_q),
        .idx_o     (pickIdx),
        .valid_o   (pickValid)
    );

    // Controller next-state: grant, strobe, wait for ack edge, wait for ack fall, report.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    owner_d = pickIdx;
                    lba_d   = req_lba[int'(pickIdx)*LBA_W +: LBA_W];
                    op_d    = req_wr[pickIdx] ? OP_WR : OP_RD;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (op_q == OP_WR) begin
                    wr_d = ownerOneHot;
                end else begin
                    rd_d = ownerOneHot;
                end
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ackRise) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = XFER;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    err_d   = ownerOneHot;
                    state_d = ABORT;
                end else if (cnt_q != {TMO_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack[owner_q]) begin
                    done_d  = ownerOneHot;
                    state_d = DONE;
                end
            end
            DONE, ABORT: begin
                ptr_d   = ownerNext;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                rd_d    = '0;
                wr_d    = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops strobes immediately and forgets the transfer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            owner_q   <= '0;
            ptr_q     <= '0;
            lba_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            done_q    <= '0;
            err_q     <= '0;
            ackPrev_q <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            lba_q     <= lba_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ackPrev_q <= sd_ack;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign sd_lba      = lba_q;
    assign req_done    = done_q;
    assign req_err     = err_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign sd_buff_din = req_buff_din[int'(owner_q)*8 +: 8];

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: requesters, an hps_io responder
// with stale/non-owner ack noise, and a monitor checking each grant and result.
module tb_sd_sector_arbiter;

    localparam int NREQ = 4;
    localparam int LBA_W = 32;
    localparam logic [23:0] TMO = 24'd16;

    logic         clk_sys = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_rd = '0;
    logic [3:0]   req_wr = '0;
    logic [127:0] req_lba = '0;
    logic [31:0]  req_buff_din = '0;
    logic [3:0]   sd_ack = '0;
    logic [3:0]   req_done, req_err, sd_rd, sd_wr;
    logic [31:0]  sd_lba;
    logic [7:0]   sd_buff_din;
    logic         busy;
    logic [1:0]   owner;

    sd_sector_arbiter #(.NREQ(NREQ), .LBA_W(LBA_W), .TIMEOUT(TMO)) dut (
        .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
        .req_lba(req_lba), .req_buff_din(req_buff_din), .req_done(req_done),
        .req_err(req_err), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .busy(busy), .owner(owner)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          owner;
        bit          wr;
        logic [31:0] lba;
        bit          noAck;
    } xfer_t;

    xfer_t expQ[$];
    int checks = 0;
    int failures = 0;

    bit          noAck[4], earlyDrop[4], again[4];
    bit          selRd[4], selWr[4], reRd[4], reWr[4];
    logic [31:0] selLba[4], reLba[4];
    int          modelPtr = 0;
    int          rState = 0, rBit = 0, rCnt = 0;
    bit          noiseOn = 0, monOn = 0;

    xfer_t       mCur;
    bit          mActive = 0, mPostEnd = 0;
    int          mLen = 0, mAckRun = 0;
    logic [3:0]  mPrevStrobe = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One negedge of environment: requesters, hps_io responder, ack noise, write data.
    task automatic applyStimulus();
        logic [3:0] strobe;
        int j;
        strobe = sd_rd | sd_wr;
        req_buff_din = $urandom;
        for (int i = 0; i < 4; i++) begin
            if (req_done[i] || req_err[i]) begin
                if (again[i]) begin
                    req_rd[i] = reRd[i];
                    req_wr[i] = reWr[i];
                    req_lba[i*32 +: 32] = reLba[i];
                    again[i] = 0;
                end else begin
                    req_rd[i] = 1'b0;
                    req_wr[i] = 1'b0;
                end
            end else if (strobe[i] && earlyDrop[i]) begin
                req_rd[i] = 1'b0;
                req_wr[i] = 1'b0;
                earlyDrop[i] = 0;
            end
        end
        case (rState)
            0: if (strobe != 0) begin
                for (int i = 0; i < 4; i++) if (strobe[i]) rBit = i;
                if (noAck[rBit]) rState = 4;
                else if (sd_ack[rBit]) begin rCnt = $urandom_range(3, 1); rState = 1; end
                else begin rCnt = $urandom_range(6, 1); rState = 2; end
            end
            1: begin
                rCnt--;
                if (rCnt == 0) begin sd_ack[rBit] = 1'b0; rCnt = $urandom_range(5, 1); rState = 2; end
            end
            2: begin
                rCnt--;
                if (rCnt == 0) begin sd_ack[rBit] = 1'b1; rCnt = $urandom_range(4, 2); rState = 3; end
            end
            3: begin
                rCnt--;
                if (rCnt == 0) begin sd_ack[rBit] = 1'b0; rState = 4; end
            end
            default: if (strobe == 0 && !busy) rState = 0;
        endcase
        if (noiseOn && $urandom_range(3, 0) == 0) begin
            j = $urandom_range(3, 0);
            if (j != int'(owner) && (rState == 0 || j != rBit)) sd_ack[j] = ~sd_ack[j];
        end
    endtask

    task automatic cycle();
        @(negedge clk_sys);
        applyStimulus();
    endtask

    // Reference model: service order is the pending set walked from the rr pointer.
    task automatic launchBatch(input logic [3:0] mask, input int againIdx);
        int order[$];
        int i;
        xfer_t t;
        for (int k = 0; k < 4; k++) begin
            i = (modelPtr + k) % 4;
            if (mask[i]) order.push_back(i);
        end
        foreach (order[n]) begin
            t.owner = order[n]; t.wr = selWr[order[n]]; t.lba = selLba[order[n]]; t.noAck = noAck[order[n]];
            expQ.push_back(t);
        end
        if (againIdx >= 0) begin
            t.owner = againIdx; t.wr = reWr[againIdx]; t.lba = reLba[againIdx]; t.noAck = 0;
            expQ.push_back(t);
            order.push_back(againIdx);
            again[againIdx] = 1;
        end
        modelPtr = (order[order.size()-1] + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                req_rd[k] = selRd[k];
                req_wr[k] = selWr[k];
                req_lba[k*32 +: 32] = selLba[k];
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(busy == 0 && req_rd == 0 && req_wr == 0 && rState == 0) && n < 600);
        checkOutput("idle_wait_expired", n >= 600, 0);
        cycle();
    endtask

    task automatic clearPlan();
        for (int i = 0; i < 4; i++) begin
            noAck[i] = 0; earlyDrop[i] = 0; again[i] = 0;
            selRd[i] = 0; selWr[i] = 0; selLba[i] = '0;
        end
    endtask

    // Monitor: pops the expected transfer at each grant and checks its whole life.
    task automatic monitorSample();
        logic [3:0] strobe, oh;
        strobe = sd_rd | sd_wr;
        if (mPostEnd) begin
            checkOutput("pulse_width", {req_done, req_err}, 0);
            checkOutput("busy_after_end", busy, 0);
            mPostEnd = 0;
        end else if (!mActive) begin
            if ((req_done | req_err) != 0) checkOutput("stray_pulse", {req_done, req_err}, 0);
            if (strobe != 0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_grant", strobe, 0);
                end else begin
                    mCur = expQ.pop_front();
                    mActive = 1;
                    mLen = 1;
                    mAckRun = sd_ack[mCur.owner] ? 1 : 0;
                    oh = 4'b1 << mCur.owner;
                    checkOutput("grant_rd", sd_rd, mCur.wr ? 4'b0 : oh);
                    checkOutput("grant_wr", sd_wr, mCur.wr ? oh : 4'b0);
                    checkOutput("grant_lba", sd_lba, mCur.lba);
                    checkOutput("grant_owner", owner, mCur.owner);
                    checkOutput("grant_busy", busy, 1);
                    checkOutput("buff_din", sd_buff_din, req_buff_din[mCur.owner*8 +: 8]);
                end
            end
        end else begin
            oh = 4'b1 << mCur.owner;
            checkOutput("buff_din", sd_buff_din, req_buff_din[mCur.owner*8 +: 8]);
            if (strobe != 0) begin
                if (mPrevStrobe == 0) checkOutput("strobe_reassert", strobe, 0);
                checkOutput("strobe_hold", strobe, oh);
                mLen++;
                mAckRun = sd_ack[mCur.owner] ? mAckRun + 1 : 0;
            end else if (mPrevStrobe != 0) begin
                if (mCur.noAck) checkOutput("timeout_len", mLen, TMO);
                else checkOutput("ack_to_drop", mAckRun, 1);
            end
            if ((req_done | req_err) != 0) begin
                checkOutput("strobe_off_at_end", strobe, 0);
                checkOutput("done", req_done, mCur.noAck ? 4'b0 : oh);
                checkOutput("err", req_err, mCur.noAck ? oh : 4'b0);
                checkOutput("busy_at_end", busy, 1);
                mActive = 0;
                mPostEnd = 1;
            end
        end
        mPrevStrobe = strobe;
    endtask

    initial begin
        forever begin
            @(negedge clk_sys);
            #1;
            if (monOn) monitorSample();
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, a;
        logic [3:0] mask;
        logic [31:0] rlba;
        xfer_t t;
        clearPlan();
        #12;
        checkOutput("rst_sd_rd", sd_rd, 0);
        checkOutput("rst_sd_wr", sd_wr, 0);
        checkOutput("rst_done", req_done, 0);
        checkOutput("rst_err", req_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_lba", sd_lba, 0);
        cycle();
        reset = 1'b0;
        monOn = 1;
        cycle();

        $display("[TB] single read from requester 0");
        clearPlan(); selRd[0] = 1; selLba[0] = 32'h10;
        launchBatch(4'b0001, -1); waitIdle();

        $display("[TB] write on 1 and read on 3 together");
        clearPlan(); selWr[1] = 1; selLba[1] = 32'hA1A1_0001; selRd[3] = 1; selLba[3] = 32'hB3B3_0003;
        launchBatch(4'b1010, -1); waitIdle();

        $display("[TB] read and write together on 2");
        clearPlan(); selRd[2] = 1; selWr[2] = 1; selLba[2] = 32'h0000_2222;
        launchBatch(4'b0100, -1); waitIdle();

        $display("[TB] timeout on requester 0");
        clearPlan(); selRd[0] = 1; selLba[0] = 32'h0000_0BAD; noAck[0] = 1;
        launchBatch(4'b0001, -1); waitIdle();

        $display("[TB] reset during transfer");
        monOn = 0;
        clearPlan();
        rlba = 32'hCAFE_0000 | ($urandom & 32'hFFFF);
        req_rd[0] = 1'b1; req_lba[31:0] = rlba;
        n = 0;
        do begin cycle(); n++; end while (!(busy && sd_rd == 0 && sd_ack[0]) && n < 60);
        checkOutput("rst_reach_xfer", n < 60, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_sd_rd", sd_rd, 0);
        checkOutput("midrst_sd_wr", sd_wr, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pulses", {req_done, req_err}, 0);
        rState = 0; sd_ack = '0;
        cycle(); cycle();
        reset = 1'b0;
        t.owner = 0; t.wr = 0; t.lba = rlba; t.noAck = 0;
        expQ.push_back(t);
        modelPtr = 1;
        mActive = 0; mPostEnd = 0; mPrevStrobe = '0;
        monOn = 1;
        waitIdle();

        $display("[TB] randomized batches with ack noise");
        noiseOn = 1;
        for (int b = 0; b < 40; b++) begin
            clearPlan();
            mask = 4'($urandom_range(15, 1));
            for (int i = 0; i < 4; i++) begin
                n = $urandom_range(2, 0);
                selRd[i] = (n != 1); selWr[i] = (n != 0);
                selLba[i] = $urandom;
                noAck[i] = ($urandom_range(4, 0) == 0);
                earlyDrop[i] = ($urandom_range(3, 0) == 0);
            end
            a = -1;
            if ($urandom_range(2, 0) == 0) begin
                do a = $urandom_range(3, 0); while (!mask[a]);
                noAck[a] = 0;
                n = $urandom_range(2, 0);
                reRd[a] = (n != 1); reWr[a] = (n != 0);
                reLba[a] = $urandom;
            end
            launchBatch(mask, a);
            waitIdle();
        end
        noiseOn = 0;
        repeat (4) cycle();
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
